// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared definitions for the control-bundle pipeline.
//   CTRL_W      width of one decoded control word
//   *_LSB/_MSB  bit offsets of each control field inside the word
//   ctrl_t      packed view of the control word (MSB first)
//   CTRL_NOP    all-zero control word, used for bubbles and squashed stages
package ctrl_pipe_pkg;

  localparam int CTRL_W    = 9;
  localparam int ALUOP_LSB = 0;
  localparam int ALUOP_MSB = 2;
  localparam int BRANCH    = 3;
  localparam int MEMWRITE  = 4;
  localparam int REGWRITE  = 5;
  localparam int MEMTOREG  = 6;
  localparam int ALUSRC    = 7;
  localparam int MEMREAD   = 8;

  typedef struct packed {
    logic       mem_read;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_bubble_if.sv
// ctrl_pipe_bubble_if: bundle of the pipeline's data and control signals.
//   Decode side (master drives): ctrl_in, valid_in, bubble, flush, hold.
//   Pipeline side (slave drives): ctrl_out (stage k at [k*CTRL_W +: CTRL_W]),
//   valid_out, flush_pend, bubble_cnt, flush_cnt.
// There is no ready/valid handshake: valid_in qualifies ctrl_in on every edge
// where the pipe is not held, and hold is a global freeze, not backpressure.
interface ctrl_pipe_bubble_if
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  logic [CTRL_W-1:0]        ctrl_in;
  logic                     valid_in;
  logic                     bubble;
  logic                     flush;
  logic                     hold;
  logic [STAGES*CTRL_W-1:0] ctrl_out;
  logic [STAGES-1:0]        valid_out;
  logic                     flush_pend;
  logic [CNT_W-1:0]         bubble_cnt;
  logic [CNT_W-1:0]         flush_cnt;

  modport master (
    output ctrl_in, valid_in, bubble, flush, hold,
    input  ctrl_out, valid_out, flush_pend, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ctrl_in, valid_in, bubble, flush, hold,
    output ctrl_out, valid_out, flush_pend, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one pipeline register holding {valid, ctrl}.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   hold        keep current contents
//   zero_load   load all zeros (bubble / squash); ignored while hold=1
//   d           next contents when neither hold nor zero_load
//   q           registered contents
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         zero_load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!hold) begin
      q_d = zero_load ? '0 : d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ctrl_pipe_bubble.sv
// ctrl_pipe_bubble: control-bundle pipeline with bubble injection, flush
// squashing and global hold.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         ctrl_pipe_bubble_if.slave (see interface header for signals)
// Per-edge priority: reset > hold > flush (incl. pending) > bubble > shift.
// A flush seen during hold is remembered in flush_pend (exposed on the bus as
// the block's only control state) and applied on the first unheld edge.
// Optional statistics counters are built only when CTRL_PIPE_STATS_EN is
// defined; otherwise bubble_cnt/flush_cnt are constant zero.
module ctrl_pipe_bubble
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_pipe_bubble_if.slave  bus
);

  localparam int SW = CTRL_W + 1;  // {valid, ctrl}

  logic              flush_pend_q;
  logic              flush_pend_d;
  logic              flush_go;
  logic              bubble_go;
  ctrl_t             ctrl0;
  logic [SW-1:0]     stage_q [STAGES];

  // Flush wins over bubble; both are suppressed by hold.
  assign flush_go  = !bus.hold && (bus.flush || flush_pend_q);
  assign bubble_go = !bus.hold && !flush_go && bus.bubble;

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (bus.hold && bus.flush) flush_pend_d = 1'b1;
    else if (flush_go)         flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) flush_pend_q <= 1'b0;
    else       flush_pend_q <= flush_pend_d;
  end

  // An invalid instruction enters as NOP so that valid=0 always means ctrl=0.
  assign ctrl0 = bus.valid_in ? ctrl_t'(bus.ctrl_in) : CTRL_NOP;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] d;
    logic          zero_load;

    if (k == 0) begin : g_head
      assign d         = {bus.valid_in, ctrl0};
      assign zero_load = flush_go || bubble_go;
    end else begin : g_body
      assign d = stage_q[k-1];
      if (k < FLUSH_DEPTH) begin : g_squash
        assign zero_load = flush_go;
      end else begin : g_keep
        assign zero_load = 1'b0;
      end
    end

    ctrl_pipe_stage #(.W(SW)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .hold      (bus.hold),
      .zero_load (zero_load),
      .d         (d),
      .q         (stage_q[k])
    );
  end

  logic [STAGES*CTRL_W-1:0] ctrl_out_w;
  logic [STAGES-1:0]        valid_out_w;

  always_comb begin
    ctrl_out_w  = '0;
    valid_out_w = '0;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_out_w[k*CTRL_W +: CTRL_W] = stage_q[k][CTRL_W-1:0];
      valid_out_w[k]                 = stage_q[k][CTRL_W];
    end
  end

  assign bus.ctrl_out   = ctrl_out_w;
  assign bus.valid_out  = valid_out_w;
  assign bus.flush_pend = flush_pend_q;

`ifdef CTRL_PIPE_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating increments: stop at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_go && (bubble_cnt_q != {CNT_W{1'b1}})) bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (flush_go  && (flush_cnt_q  != {CNT_W{1'b1}})) flush_cnt_d  = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`else
  assign bus.bubble_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ctrl_pipe_bubble.sv
// tb_ctrl_pipe_bubble: directed scenarios followed by random traffic, every
// cycle compared against a list-style reference model of the pipeline.
// Counter expectations follow CTRL_PIPE_STATS_EN (zero when undefined).
module tb_ctrl_pipe_bubble;
  import ctrl_pipe_pkg::*;

  localparam int STAGES      = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef CTRL_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_bubble_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

  ctrl_pipe_bubble #(
    .STAGES      (STAGES),
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  int m_ctrl  [STAGES];
  bit m_valid [STAGES];
  bit m_pend;
  int m_bubbles;
  int m_flushes;

  int n_checks = 0;
  int n_errors = 0;

  task automatic model_step(input bit r, input bit h, input bit f, input bit b,
                            input bit v, input int c);
    if (r) begin
      for (int k = 0; k < STAGES; k++) begin m_ctrl[k] = 0; m_valid[k] = 0; end
      m_pend = 0; m_bubbles = 0; m_flushes = 0;
    end else if (h) begin
      if (f) m_pend = 1;
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        m_ctrl[k] = m_ctrl[k-1]; m_valid[k] = m_valid[k-1];
      end
      if (f || m_pend) begin
        for (int k = 0; k < FLUSH_DEPTH; k++) begin m_ctrl[k] = 0; m_valid[k] = 0; end
        m_pend = 0;
        m_flushes++;
      end else if (b) begin
        m_ctrl[0] = 0; m_valid[0] = 0;
        m_bubbles++;
      end else begin
        m_ctrl[0] = v ? c : 0; m_valid[0] = v;
      end
    end
  endtask

  function automatic int exp_cnt(input int raw);
    if (!STATS) return 0;
    return (raw > CNT_MAX) ? CNT_MAX : raw;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [STAGES*CTRL_W-1:0] e_ctrl;
    logic [STAGES-1:0]        e_valid;
    e_ctrl = '0; e_valid = '0;
    for (int k = 0; k < STAGES; k++) begin
      e_ctrl[k*CTRL_W +: CTRL_W] = m_ctrl[k][CTRL_W-1:0];
      e_valid[k]                 = m_valid[k];
    end
    chk({tag, ".ctrl_out"},   32'(bus.ctrl_out),   32'(e_ctrl));
    chk({tag, ".valid_out"},  32'(bus.valid_out),  32'(e_valid));
    chk({tag, ".flush_pend"}, 32'(bus.flush_pend), 32'(m_pend));
    chk({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(exp_cnt(m_bubbles)));
    chk({tag, ".flush_cnt"},  32'(bus.flush_cnt),  32'(exp_cnt(m_flushes)));
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled on the next falling
  // edge, after the rising edge that consumed them.
  task automatic step(input string tag, input bit r, input bit h, input bit f,
                      input bit b, input bit v, input int c);
    reset        = r;
    bus.hold     = h;
    bus.flush    = f;
    bus.bubble   = b;
    bus.valid_in = v;
    bus.ctrl_in  = c[CTRL_W-1:0];
    @(posedge clk);
    model_step(r, h, f, b, v, c);
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [31:0] stage_of(input int k);
    return 32'(bus.ctrl_out[k*CTRL_W +: CTRL_W]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; bus.hold = 0; bus.flush = 0; bus.bubble = 0;
    bus.valid_in = 0; bus.ctrl_in = '0;
    for (int k = 0; k < STAGES; k++) begin m_ctrl[k] = 0; m_valid[k] = 0; end
    m_pend = 0; m_bubbles = 0; m_flushes = 0;
    @(negedge clk);

    // 1: reset, fill with 0x1A5, reset mid-stream
    step("t1_rst0", 1, 0, 0, 0, 0, 0);
    step("t1_rst1", 1, 0, 0, 0, 0, 0);
    step("t1_in0", 0, 0, 0, 0, 1, 'h1A5);
    step("t1_in1", 0, 0, 0, 0, 1, 'h1A5);
    step("t1_in2", 0, 0, 0, 0, 1, 'h1A5);
    chk("t1_stage2", stage_of(2), 32'h1A5);
    chk("t1_valid", 32'(bus.valid_out), 32'h7);
    step("t1_in3", 0, 0, 0, 0, 1, 'h1A5);
    step("t1_midrst", 1, 0, 0, 0, 1, 'h1A5);
    chk("t1_rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    chk("t1_rst_valid", 32'(bus.valid_out), 32'h0);

    // 2: bubble in the middle of a stream
    step("t2_a", 0, 0, 0, 0, 1, 'h011);
    chk("t2_s0_a", stage_of(0), 32'h011);
    step("t2_b", 0, 0, 0, 1, 1, 'h022);
    chk("t2_s0_b", stage_of(0), 32'h000);
    chk("t2_v0_b", 32'(bus.valid_out[0]), 32'h0);
    step("t2_c", 0, 0, 0, 0, 1, 'h033);
    chk("t2_s0_c", stage_of(0), 32'h033);
    chk("t2_bcnt", 32'(bus.bubble_cnt), STATS ? 32'd1 : 32'd0);

    // 3: full of 0x0FF, single flush
    step("t3_rst", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < STAGES; i++) step("t3_fill", 0, 0, 0, 0, 1, 'h0FF);
    step("t3_flush", 0, 0, 1, 0, 1, 'h055);
    chk("t3_s0", stage_of(0), 32'h0);
    chk("t3_s1", stage_of(1), 32'h0);
    chk("t3_s2", stage_of(2), 32'h0FF);
    chk("t3_valid", 32'(bus.valid_out), 32'h4);
    chk("t3_fcnt", 32'(bus.flush_cnt), STATS ? 32'd1 : 32'd0);

    // 4: flush during hold is remembered, repeated flush counts once
    step("t4_rst", 1, 0, 0, 0, 0, 0);
    step("t4_fill0", 0, 0, 0, 0, 1, 'h101);
    step("t4_fill1", 0, 0, 0, 0, 1, 'h102);
    step("t4_fill2", 0, 0, 0, 0, 1, 'h103);
    step("t4_h0", 0, 1, 0, 1, 1, 'h1FF);
    step("t4_h1", 0, 1, 1, 0, 1, 'h1FF);
    chk("t4_pend", 32'(bus.flush_pend), 32'h1);
    step("t4_h2", 0, 1, 1, 0, 1, 'h1FF);
    chk("t4_frozen", stage_of(0), 32'h103);
    step("t4_release", 0, 0, 0, 0, 1, 'h104);
    chk("t4_pend_clr", 32'(bus.flush_pend), 32'h0);
    chk("t4_s2", stage_of(2), 32'h102);
    chk("t4_fcnt", 32'(bus.flush_cnt), STATS ? 32'd1 : 32'd0);

    // 5: flush and bubble together -> flush only
    step("t5_fill", 0, 0, 0, 0, 1, 'h0AA);
    step("t5_both", 0, 0, 1, 1, 1, 'h0BB);
    chk("t5_bcnt", 32'(bus.bubble_cnt), 32'h0);

    // 6: 20 bubbles saturate a 4-bit counter
    step("t6_rst", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("t6_bub", 0, 0, 0, 1, 1, 'h1C3);
    chk("t6_bsat", 32'(bus.bubble_cnt), STATS ? 32'd15 : 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 80),
           int'($urandom_range(0, (1 << CTRL_W) - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
